// File: rtl/crono_countdown_if.sv
// crono_countdown_if: control/status bundle between a timer front end and crono_countdown
// Ports: programReq/set_h/set_m/set_s load a time, start/stop/ack steer the countdown,
//   crono_activo/ring/hh/mm/ss/state report the live countdown back.
// programReq carries the "program" strobe; "program" itself is a reserved word.
interface crono_countdown_if;
  logic       programReq;
  logic [4:0] set_h;
  logic [5:0] set_m;
  logic [5:0] set_s;
  logic       start;
  logic       stop;
  logic       ack;
  logic       crono_activo;
  logic       ring;
  logic [4:0] hh;
  logic [5:0] mm;
  logic [5:0] ss;
  logic [2:0] state;
  modport master (
    output programReq, set_h, set_m, set_s, start, stop, ack,
    input  crono_activo, ring, hh, mm, ss, state
  );
  modport slave (
    input  programReq, set_h, set_m, set_s, start, stop, ack,
    output crono_activo, ring, hh, mm, ss, state
  );
endinterface

// File: rtl/crono_countdown.sv
// crono_countdown: hh:mm:ss countdown chronometer with pause/resume and ring phase
// Ports: clk, reset (async, active-high), bus (crono_countdown_if.slave).
// Optional macro CRONO_RING_TIMEOUT_EN: RING leaves to IDLE by itself after RING_SECS ticks.
module crono_countdown #(
  parameter int TICK_DIV  = 100000000,
  parameter int HOUR_MAX  = 23,
  parameter int RING_SECS = 10
) (
  input logic             clk,
  input logic             reset,
  crono_countdown_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TICK_TOP = PW'(TICK_DIV - 1);
  typedef enum logic [2:0] {IDLE = 3'd0, RUN = 3'd1, PAUSE = 3'd2, RING = 3'd3} state_t;
  state_t stateQ, stateD;
  logic [PW-1:0] presc, prescD;
  logic [4:0] hh, hhD, loadH;
  logic [5:0] mm, mmD, ss, ssD, loadM, loadS;
  logic activo, ringQ, tick, lastSec;
`ifdef CRONO_RING_TIMEOUT_EN
  logic [7:0] ringCnt, ringCntD;
`endif
  assign tick = presc == TICK_TOP;
  assign lastSec = ~|{hh, mm} && ss == 6'd1;
  assign loadH = bus.set_h > 5'(HOUR_MAX) ? 5'(HOUR_MAX) : bus.set_h;
  assign loadM = bus.set_m > 6'd59 ? 6'd59 : bus.set_m;
  assign loadS = bus.set_s > 6'd59 ? 6'd59 : bus.set_s;
  always_comb begin
    stateD = stateQ;
    prescD = presc;
    hhD = hh;
    mmD = mm;
    ssD = ss;
`ifdef CRONO_RING_TIMEOUT_EN
    ringCntD = ringCnt;
`endif
    case (stateQ)
      IDLE:
        // a load in the same cycle as start wins; start is seen again next cycle
        if (bus.programReq) begin
          hhD = loadH;
          mmD = loadM;
          ssD = loadS;
        end else if (bus.start && |{hh, mm, ss}) begin
          stateD = RUN;
          prescD = '0;
        end
      RUN:
        if (bus.stop) stateD = PAUSE;
        else if (tick) begin
          prescD = '0;
          if (|ss) ssD = ss - 6'd1;
          else if (|mm) begin
            mmD = mm - 6'd1;
            ssD = 6'd59;
          end else begin
            hhD = hh - 5'd1;
            mmD = 6'd59;
            ssD = 6'd59;
          end
          if (lastSec) stateD = RING;
`ifdef CRONO_RING_TIMEOUT_EN
          ringCntD = '0;
`endif
        end else prescD = presc + 1'b1;
      PAUSE:
        if (bus.stop) begin
          stateD = IDLE;
          hhD = '0;
          mmD = '0;
          ssD = '0;
        end else if (bus.start) stateD = RUN;
      RING:
        if (bus.ack) stateD = IDLE;
`ifdef CRONO_RING_TIMEOUT_EN
        else if (tick) begin
          prescD = '0;
          ringCntD = ringCnt + 8'd1;
          if (ringCnt == 8'(RING_SECS - 1)) stateD = IDLE;
        end else prescD = presc + 1'b1;
`endif
      default: stateD = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ <= IDLE;
      presc <= '0;
      hh <= '0;
      mm <= '0;
      ss <= '0;
      activo <= 1'b0;
      ringQ <= 1'b0;
`ifdef CRONO_RING_TIMEOUT_EN
      ringCnt <= '0;
`endif
    end else begin
      stateQ <= stateD;
      presc <= prescD;
      hh <= hhD;
      mm <= mmD;
      ss <= ssD;
      activo <= stateD == RUN || stateD == PAUSE;
      ringQ <= stateD == RING;
`ifdef CRONO_RING_TIMEOUT_EN
      ringCnt <= ringCntD;
`endif
    end
  end
  assign bus.crono_activo = activo;
  assign bus.ring = ringQ;
  assign bus.hh = hh;
  assign bus.mm = mm;
  assign bus.ss = ss;
  assign bus.state = stateQ;
endmodule

// File: tb/tb_crono_countdown.sv
// tb_crono_countdown: directed checks of crono_countdown against a seconds-level model
module tb_crono_countdown;
  localparam int TD = 4;
  localparam int HM = 23;
  localparam int RS = 3;
  logic clk = 1'b0;
  logic reset;
  int errs = 0;
  int checks = 0;
  int mState = 0;
  int rem = 0;
  int pre = 0;
  int ringTicks = 0;
  int n;
  crono_countdown_if ifc();
  crono_countdown #(.TICK_DIV(TD), .HOUR_MAX(HM), .RING_SECS(RS)) dut (
    .clk(clk),
    .reset(reset),
    .bus(ifc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic int sat(input int v, input int m);
    return v > m ? m : v;
  endfunction
  // model: remaining time kept as total seconds, states by their output codes
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mState = 0;
      rem = 0;
      pre = 0;
      ringTicks = 0;
    end else if (mState == 0) begin
      if (ifc.programReq)
        rem = sat(int'(ifc.set_h), HM) * 3600 + sat(int'(ifc.set_m), 59) * 60 + sat(int'(ifc.set_s), 59);
      else if (ifc.start && rem > 0) begin
        mState = 1;
        pre = 0;
      end
    end else if (mState == 1) begin
      if (ifc.stop) mState = 2;
      else if (pre == TD - 1) begin
        pre = 0;
        rem = rem - 1;
        if (rem == 0) begin
          mState = 3;
          ringTicks = 0;
        end
      end else pre = pre + 1;
    end else if (mState == 2) begin
      if (ifc.stop) begin
        mState = 0;
        rem = 0;
      end else if (ifc.start) mState = 1;
    end else begin
      if (ifc.ack) mState = 0;
`ifdef CRONO_RING_TIMEOUT_EN
      else if (pre == TD - 1) begin
        pre = 0;
        ringTicks = ringTicks + 1;
        if (ringTicks == RS) mState = 0;
      end else pre = pre + 1;
`endif
    end
  end
  always @(negedge clk)
    chk("cycle", {10'd0, ifc.state, ifc.crono_activo, ifc.ring, ifc.hh, ifc.mm, ifc.ss},
        {10'd0, 3'(mState), mState == 1 || mState == 2, mState == 3,
         5'(rem / 3600), 6'((rem / 60) % 60), 6'(rem % 60)});
  task automatic load(input int h, input int m, input int s);
    ifc.set_h = 5'(h);
    ifc.set_m = 6'(m);
    ifc.set_s = 6'(s);
    ifc.programReq = 1'b1;
    @(negedge clk);
    ifc.programReq = 1'b0;
  endtask
  task automatic pulse_start();
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
  endtask
  task automatic pulse_stop();
    ifc.stop = 1'b1;
    @(negedge clk);
    ifc.stop = 1'b0;
  endtask
  task automatic pulse_ack();
    ifc.ack = 1'b1;
    @(negedge clk);
    ifc.ack = 1'b0;
  endtask
  initial begin
    ifc.programReq = 1'b0;
    ifc.set_h = '0;
    ifc.set_m = '0;
    ifc.set_s = '0;
    ifc.start = 1'b0;
    ifc.stop = 1'b0;
    ifc.ack = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_state", ifc.state, 0);
    chk("rst_time", {ifc.hh, ifc.mm, ifc.ss}, 0);
    chk("rst_flags", {ifc.crono_activo, ifc.ring}, 0);
    reset = 1'b0;
    @(negedge clk);
    load(0, 1, 2);
    chk("t1_load", {ifc.hh, ifc.mm, ifc.ss}, {5'd0, 6'd1, 6'd2});
    pulse_start();
    chk("t1_activo", ifc.crono_activo, 1);
    n = 0;
    while (!ifc.ring && n < 1000) begin
      @(negedge clk);
      n++;
      if (n == 4) chk("t1_dec1", {ifc.hh, ifc.mm, ifc.ss}, {5'd0, 6'd1, 6'd1});
      if (n == 8) chk("t1_dec2", {ifc.hh, ifc.mm, ifc.ss}, {5'd0, 6'd1, 6'd0});
      if (n == 12) chk("t1_dec3", {ifc.hh, ifc.mm, ifc.ss}, {5'd0, 6'd0, 6'd59});
    end
    chk("t1_ring_latency", n, 248);
    chk("t1_ring_flags", {ifc.crono_activo, ifc.ring, ifc.state}, {2'b01, 3'd3});
    pulse_ack();
    chk("t1_ack_idle", {ifc.ring, ifc.state}, 0);
    load(1, 0, 0);
    pulse_start();
    repeat (4) @(negedge clk);
    chk("t2_borrow", {ifc.hh, ifc.mm, ifc.ss}, {5'd0, 6'd59, 6'd59});
    chk("t2_activo", ifc.crono_activo, 1);
    pulse_stop();
    chk("t2_pause", ifc.state, 2);
    pulse_stop();
    chk("t2_abort", {ifc.state, ifc.hh, ifc.mm, ifc.ss}, 0);
    load(31, 63, 60);
    chk("t3_saturate", {ifc.hh, ifc.mm, ifc.ss}, {5'd23, 6'd59, 6'd59});
    load(0, 0, 0);
    pulse_start();
    repeat (3) @(negedge clk);
    chk("t3_zero_start", {ifc.state, ifc.crono_activo}, 0);
    load(0, 0, 10);
    pulse_start();
    repeat (2) @(negedge clk);
    pulse_stop();
    chk("t4_paused", ifc.state, 2);
    repeat (20) @(negedge clk);
    chk("t4_frozen", {ifc.state, ifc.ss}, {3'd2, 6'd10});
    pulse_start();
    chk("t4_resumed", {ifc.state, ifc.ss}, {3'd1, 6'd10});
    @(negedge clk);
    chk("t4_not_yet", ifc.ss, 10);
    @(negedge clk);
    chk("t4_resume_dec", ifc.ss, 9);
    n = 0;
    while (!ifc.ring && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t4_ring", ifc.ring, 1);
`ifdef CRONO_RING_TIMEOUT_EN
    n = 0;
    while (ifc.state != 3'd0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t4_ring_timeout", n, 12);
`else
    repeat (1000) @(negedge clk);
    chk("t4_ring_hold", {ifc.ring, ifc.state}, {1'b1, 3'd3});
`endif
    pulse_ack();
    chk("t4_ack_idle", {ifc.ring, ifc.state}, 0);
    load(0, 0, 8);
    pulse_start();
    n = 0;
    while (ifc.ss != 6'd5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reach5", ifc.ss, 5);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_state", ifc.state, 0);
    chk("t5_async_time", {ifc.hh, ifc.mm, ifc.ss}, 0);
    chk("t5_async_flags", {ifc.crono_activo, ifc.ring}, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    chk("t5_no_ring", {ifc.ring, ifc.state}, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
